// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter
//
// Shares one 8-bit-data / 5-bit-address Wishbone register bus between
// NUM_MASTERS masters (2..4). Every master strobe is latched into a
// per-master slot. The slots are served round-robin, one slave transaction
// at a time. A watchdog completes a transaction with an error if the slave
// never acks.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   m_cyc_i/m_stb_i       per-master request (valid when cyc & stb)
//   m_we_i/m_sel_i        per-master write enable / byte select
//   m_adr_i/m_dat_i       packed per-master address (5b) / write data (8b)
//   m_dat_o               read data, shared, held until the next completion
//   m_ack_o/m_err_o       per-master completion / timeout pulses
//   s_cyc_o/s_stb_o       slave strobe, high for a single cycle
//   s_we_o/s_sel_o        slave write enable / byte select
//   s_adr_o/s_dat_o       slave address / write data
//   s_dat_i/s_ack_i       slave read data / ack
//   grant_o               one-hot owner of the current transaction
//   busy_o                high while a transaction is in ISSUE or WAIT
module wb_master_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_MASTERS-1:0]     m_cyc_i,
    input  logic [NUM_MASTERS-1:0]     m_stb_i,
    input  logic [NUM_MASTERS-1:0]     m_we_i,
    input  logic [NUM_MASTERS-1:0]     m_sel_i,
    input  logic [5*NUM_MASTERS-1:0]   m_adr_i,
    input  logic [8*NUM_MASTERS-1:0]   m_dat_i,
    output logic [7:0]                 m_dat_o,
    output logic [NUM_MASTERS-1:0]     m_ack_o,
    output logic [NUM_MASTERS-1:0]     m_err_o,
    output logic                       s_cyc_o,
    output logic                       s_stb_o,
    output logic                       s_we_o,
    output logic                       s_sel_o,
    output logic [4:0]                 s_adr_o,
    output logic [7:0]                 s_dat_o,
    input  logic [7:0]                 s_dat_i,
    input  logic                       s_ack_i,
    output logic [NUM_MASTERS-1:0]     grant_o,
    output logic                       busy_o
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_MASTERS - 1);
    localparam logic [7:0]       WDOG_LAST = 8'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t                 state;
    logic [NUM_MASTERS-1:0] pending;
    logic                   slot_we  [NUM_MASTERS];
    logic                   slot_sel [NUM_MASTERS];
    logic [4:0]             slot_adr [NUM_MASTERS];
    logic [7:0]             slot_dat [NUM_MASTERS];
    logic [IDX_W-1:0]       last_grant;
    logic [7:0]             wdog;

    logic [NUM_MASTERS-1:0] req;
    logic                   expire;
    logic                   complete;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick;

    assign req = m_cyc_i & m_stb_i;

    // The watchdog only runs in WAIT, so its first WAIT cycle reads 0 and
    // the expiry cycle lies TIMEOUT cycles after the strobe cycle.
    assign expire   = (TIMEOUT != 0) && (wdog == WDOG_LAST);
    assign complete = ((state == ISSUE) && s_ack_i) ||
                      ((state == WAIT) && (s_ack_i || expire));

    // Round-robin search. Walking the offsets from largest to smallest lets
    // the nearest pending master after last_grant overwrite the others.
    always_comb begin
        pick_valid = 1'b0;
        pick       = last_grant;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            if (pending[(int'(last_grant) + k) % NUM_MASTERS]) begin
                pick_valid = 1'b1;
                pick       = IDX_W'((int'(last_grant) + k) % NUM_MASTERS);
            end
        end
    end

    // Request capture. grant_o is one-hot of the master being served, so
    // complete & grant_o[i] marks the cycle master i finishes; a strobe in
    // that same cycle re-arms its slot instead of being dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                slot_we[i]  <= 1'b0;
                slot_sel[i] <= 1'b0;
                slot_adr[i] <= '0;
                slot_dat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (complete && grant_o[i]) begin
                    pending[i] <= 1'b0;
                end
                if (req[i] && (!pending[i] || (complete && grant_o[i]))) begin
                    pending[i]  <= 1'b1;
                    slot_we[i]  <= m_we_i[i];
                    slot_sel[i] <= m_sel_i[i];
                    slot_adr[i] <= m_adr_i[5*i +: 5];
                    slot_dat[i] <= m_dat_i[8*i +: 8];
                end
            end
        end
    end

    // Transaction FSM with registered bus outputs. After any completion it
    // always returns to IDLE, giving the mandatory one-cycle gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= LAST_IDX;
            wdog       <= '0;
            grant_o    <= '0;
            busy_o     <= 1'b0;
            m_ack_o    <= '0;
            m_err_o    <= '0;
            m_dat_o    <= '0;
            s_cyc_o    <= 1'b0;
            s_stb_o    <= 1'b0;
            s_we_o     <= 1'b0;
            s_sel_o    <= 1'b0;
            s_adr_o    <= '0;
            s_dat_o    <= '0;
        end else begin
            m_ack_o <= '0;
            m_err_o <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        s_cyc_o    <= 1'b1;
                        s_stb_o    <= 1'b1;
                        s_we_o     <= slot_we[pick];
                        s_sel_o    <= slot_sel[pick];
                        s_adr_o    <= slot_adr[pick];
                        s_dat_o    <= slot_dat[pick];
                        grant_o    <= NUM_MASTERS'(1) << pick;
                        last_grant <= pick;
                        busy_o     <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    s_cyc_o <= 1'b0;
                    s_stb_o <= 1'b0;
                    wdog    <= '0;
                    if (s_ack_i) begin
                        m_ack_o <= grant_o;
                        m_dat_o <= s_dat_i;
                        grant_o <= '0;
                        busy_o  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // A late ack on the expiry cycle still counts as success.
                    if (s_ack_i) begin
                        m_ack_o <= grant_o;
                        m_dat_o <= s_dat_i;
                        grant_o <= '0;
                        busy_o  <= 1'b0;
                        state   <= IDLE;
                    end else if (expire) begin
                        m_ack_o <= grant_o;
                        m_err_o <= grant_o;
                        m_dat_o <= 8'hFF;
                        grant_o <= '0;
                        busy_o  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
